// File: rtl/cpu_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : cpu_prefetch_queue
// Purpose  : Instruction prefetch queue between the CPU fetch stage and the
//            instruction bus. Keeps up to DEPTH sequential words ahead of the
//            CPU, serves sequential fetches in one cycle and restarts fetching
//            on a non-sequential fetch or an explicit flush.
// Ports    : i_clock, i_reset (async, active-low)
//            CPU : i_request, i_address, o_ready, o_rdata, i_flush, o_level
//            Bus : o_bus_request, o_bus_address, i_bus_ready, i_bus_rdata
// Revision : 1.0 - initial release
// ============================================================================
module cpu_prefetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRIDE     = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_request,
  output logic                      o_ready,
  input  logic [ADDR_WIDTH-1:0]     i_address,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  input  logic                      i_flush,
  output logic [$clog2(DEPTH):0]    o_level,
  output logic                      o_bus_request,
  input  logic                      i_bus_ready,
  output logic [ADDR_WIDTH-1:0]     o_bus_address,
  input  logic [DATA_WIDTH-1:0]     i_bus_rdata
);

  localparam int                    c_ptr_w   = $clog2(DEPTH);
  localparam int                    c_lvl_w   = c_ptr_w + 1;
  localparam logic [ADDR_WIDTH-1:0] c_stride  = ADDR_WIDTH'(STRIDE);
  localparam logic [c_lvl_w-1:0]    c_depth   = c_lvl_w'(DEPTH);
  localparam logic [c_lvl_w-1:0]    c_lvl_one = c_lvl_w'(1);
  localparam logic [c_ptr_w-1:0]    c_ptr_one = c_ptr_w'(1);

  // Queue storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_lvl_w-1:0]    count_q, count_d;

  // Address tracking
  logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;

  // Control flags
  logic                  pending_miss_q, pending_miss_d;
  logic                  discard_q, discard_d;
  logic                  prefetch_en_q, prefetch_en_d;

  // Registered outputs
  logic                  bus_req_q, bus_req_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Decoded events for this edge
  logic w_bus_done;
  logic w_req_ok;
  logic w_hit;
  logic w_bypass;
  logic w_miss;
  logic w_clear;
  logic w_push;
  logic w_pop;

  always_comb begin
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    head_addr_d    = head_addr_q;
    fetch_addr_d   = fetch_addr_q;
    miss_addr_d    = miss_addr_q;
    pending_miss_d = pending_miss_q;
    discard_d      = discard_q;
    prefetch_en_d  = prefetch_en_q;
    bus_req_d      = bus_req_q;
    bus_addr_d     = bus_addr_q;
    ready_d        = 1'b0;
    rdata_d        = rdata_q;
    w_clear        = 1'b0;
    w_push         = 1'b0;
    w_pop          = 1'b0;

    w_bus_done = bus_req_q & i_bus_ready;
    // A waiting miss keeps i_request high; it must not be re-decoded.
    w_req_ok   = i_request & ~ready_q & ~pending_miss_q;
    // Flush wins over a same-edge request, which then always decodes as a miss.
    w_hit      = w_req_ok & ~i_flush & (count_q != '0) & (i_address == head_addr_q);
    w_bypass   = w_req_ok & ~i_flush & (count_q == '0) & bus_req_q & ~discard_q &
                 (bus_addr_q == i_address);
    w_miss     = w_req_ok & ~w_hit & ~w_bypass;

    if (i_flush || w_miss) begin
      w_clear       = 1'b1;
      prefetch_en_d = 1'b0;
      // A read completing on this very edge is simply dropped below, so only
      // a read that stays outstanding needs the stale marker.
      if (bus_req_q && !w_bus_done) begin
        discard_d = 1'b1;
      end
    end

    if (w_miss) begin
      pending_miss_d = 1'b1;
      miss_addr_d    = i_address;
    end

    if (w_bus_done) begin
      bus_req_d = 1'b0;
      if (discard_q) begin
        discard_d = 1'b0;
      end else if (pending_miss_q) begin
        // A flush racing the miss word drops it; the miss is re-issued.
        if (!i_flush) begin
          ready_d        = 1'b1;
          rdata_d        = i_bus_rdata;
          pending_miss_d = 1'b0;
          prefetch_en_d  = 1'b1;
          head_addr_d    = miss_addr_q + c_stride;
          fetch_addr_d   = miss_addr_q + c_stride;
          w_clear        = 1'b1;
        end
      end else if (w_bypass) begin
        // Word goes straight to the CPU; the next queued word is fetch_addr.
        ready_d     = 1'b1;
        rdata_d     = i_bus_rdata;
        head_addr_d = fetch_addr_q;
      end else if (!w_clear) begin
        w_push = 1'b1;
      end
    end

    if (w_hit) begin
      w_pop       = 1'b1;
      ready_d     = 1'b1;
      rdata_d     = mem_q[rd_ptr_q];
      head_addr_d = head_addr_q + c_stride;
    end

    if (w_clear) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + c_ptr_one;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        count_d = count_q + c_lvl_one;
      end else if (w_pop && !w_push) begin
        count_d = count_q - c_lvl_one;
      end
    end

    // Issue only from a fully idle bus so the request drops for at least one
    // cycle after every completion. With the bus idle nothing is in flight,
    // so count_d alone bounds the space reserved in the queue.
    if (!bus_req_q) begin
      if (pending_miss_d) begin
        bus_req_d  = 1'b1;
        bus_addr_d = miss_addr_d;
      end else if (prefetch_en_d && (count_d < c_depth)) begin
        bus_req_d    = 1'b1;
        bus_addr_d   = fetch_addr_d;
        fetch_addr_d = fetch_addr_d + c_stride;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      head_addr_q    <= '0;
      fetch_addr_q   <= '0;
      miss_addr_q    <= '0;
      pending_miss_q <= 1'b0;
      discard_q      <= 1'b0;
      prefetch_en_q  <= 1'b0;
      bus_req_q      <= 1'b0;
      bus_addr_q     <= '0;
      ready_q        <= 1'b0;
      rdata_q        <= '0;
    end else begin
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      head_addr_q    <= head_addr_d;
      fetch_addr_q   <= fetch_addr_d;
      miss_addr_q    <= miss_addr_d;
      pending_miss_q <= pending_miss_d;
      discard_q      <= discard_d;
      prefetch_en_q  <= prefetch_en_d;
      bus_req_q      <= bus_req_d;
      bus_addr_q     <= bus_addr_d;
      ready_q        <= ready_d;
      rdata_q        <= rdata_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are valid.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= i_bus_rdata;
    end
  end

  assign o_ready       = ready_q;
  assign o_rdata       = rdata_q;
  assign o_level       = count_q;
  assign o_bus_request = bus_req_q;
  assign o_bus_address = bus_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_prefetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cpu_prefetch_queue
// Purpose  : Directed self-checking bench for cpu_prefetch_queue (DEPTH=4,
//            32-bit address/data, stride 4). Bus slave returns
//            addr ^ 0xAAAA0101 after a programmable number of wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_prefetch_queue;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        flush;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        o_ready;
  logic [31:0] o_rdata;
  logic [2:0]  o_level;
  logic        o_bus_request;
  logic [31:0] o_bus_address;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          bus_wait = 0;
  int          bus_cnt  = 0;
  logic [31:0] bus_log[$];

  cpu_prefetch_queue #(
    .DEPTH      (4),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .STRIDE     (4)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_request     (req),
    .o_ready       (o_ready),
    .i_address     (addr),
    .o_rdata       (o_rdata),
    .i_flush       (flush),
    .o_level       (o_level),
    .o_bus_request (o_bus_request),
    .i_bus_ready   (bus_ready),
    .o_bus_address (o_bus_address),
    .i_bus_rdata   (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus slave: answers a held request after bus_wait falling edges.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ready <= 1'b0;
      bus_cnt   <= 0;
    end else if (!o_bus_request || bus_ready) begin
      bus_ready <= 1'b0;
      bus_cnt   <= 0;
    end else if (bus_cnt >= bus_wait) begin
      bus_ready <= 1'b1;
      bus_rdata <= o_bus_address ^ 32'hAAAA0101;
      bus_log.push_back(o_bus_address);
    end else begin
      bus_cnt <= bus_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch_start(input logic [31:0] a, input logic fl);
    @(negedge clk);
    while (o_ready) @(negedge clk);
    addr  = a;
    req   = 1'b1;
    flush = fl;
  endtask

  task automatic fetch_wait(input string tag, output logic [31:0] d, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    d   = '0;
    while (!got && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      flush = 1'b0;
      if (o_ready) begin
        got = 1'b1;
        d   = o_rdata;
        req = 1'b0;
      end
    end
    req = 1'b0;
    check({tag, " ready seen"}, got, 1'b1);
  endtask

  logic [31:0] d;
  int          lat;
  int          n0;
  logic [31:0] hit_a [3] = '{32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
  logic [31:0] hit_d [3] = '{32'hAAAA_0005, 32'hAAAA_0009, 32'hAAAA_000D};

  initial begin
    rst_n    = 1'b0;
    req      = 1'b0;
    addr     = '0;
    flush    = 1'b0;
    bus_wait = 3;

    // Reset state
    #12;
    check("rst ready",    o_ready,       1'b0);
    check("rst rdata",    o_rdata,       32'h0);
    check("rst bus_req",  o_bus_request, 1'b0);
    check("rst bus_addr", o_bus_address, 32'h0);
    check("rst level",    o_level,       3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(3);
    check("idle no fetch", o_bus_request, 1'b0);

    // Cold miss at 0x100, 3 wait cycles
    fetch_start(32'h100, 1'b0);
    @(posedge clk);
    #1;
    check("cold bus_req",  o_bus_request, 1'b1);
    check("cold bus_addr", o_bus_address, 32'h100);
    check("cold level",    o_level,       3'd0);
    fetch_wait("cold", d, lat);
    check("cold data", d, 32'hAAAA_0001);
    @(posedge clk);
    #1;
    check("cold ready single", o_ready, 1'b0);
    wait_cycles(40);
    check("fill level",     o_level,         3'd4);
    check("fill reads",     bus_log.size(),  5);
    check("fill read 1",    bus_log[1],      32'h104);
    check("fill read 4",    bus_log[4],      32'h110);
    check("full no issue",  o_bus_request,   1'b0);

    // Sequential hits with a zero-wait bus
    bus_wait = 0;
    for (int i = 0; i < 3; i++) begin
      fetch_start(hit_a[i], 1'b0);
      fetch_wait("hit", d, lat);
      check("hit data",    d,   hit_d[i]);
      check("hit latency", lat, 1);
      check("hit level range", (o_level >= 3'd3) && (o_level <= 3'd4), 1'b1);
    end
    wait_cycles(20);
    check("refill level", o_level, 3'd4);

    // Redirect while a read is in flight
    bus_wait = 1000;
    fetch_start(32'h110, 1'b0);
    fetch_wait("hit 110", d, lat);
    check("hit 110 data",    d,   32'hAAAA_0011);
    check("hit 110 latency", lat, 1);
    @(posedge clk);
    #1;
    check("inflight bus_req",  o_bus_request, 1'b1);
    check("inflight bus_addr", o_bus_address, 32'h120);
    check("inflight level",    o_level,       3'd3);
    fetch_start(32'h2000, 1'b0);
    @(posedge clk);
    #1;
    check("redirect level", o_level, 3'd0);
    check("redirect ready", o_ready, 1'b0);
    bus_wait = 2;
    fetch_wait("redirect", d, lat);
    bus_wait = 1000;
    check("redirect data",      d, 32'hAAAA_2101);
    check("redirect stale rd",  bus_log[bus_log.size() - 2], 32'h120);
    check("redirect new rd",    bus_log[bus_log.size() - 1], 32'h2000);

    // Bypass: empty queue, 0x2004 in flight
    fetch_start(32'h2004, 1'b0);
    wait_cycles(3);
    check("bypass wait ready", o_ready,       1'b0);
    check("bypass bus_req",    o_bus_request, 1'b1);
    check("bypass bus_addr",   o_bus_address, 32'h2004);
    check("bypass level",      o_level,       3'd0);
    n0 = bus_log.size();
    bus_wait = 0;
    fetch_wait("bypass", d, lat);
    check("bypass data",     d,              32'hAAAA_2105);
    check("bypass one read", bus_log.size(), n0 + 1);
    wait_cycles(30);
    check("post bypass level", o_level, 3'd4);
    fetch_start(32'h2008, 1'b0);
    fetch_wait("post bypass hit", d, lat);
    check("post bypass data",    d,   32'hAAAA_2109);
    check("post bypass latency", lat, 1);
    wait_cycles(10);

    // Flush together with a request that would hit
    fetch_start(32'h200C, 1'b1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush+req ready",    o_ready,       1'b0);
    check("flush+req level",    o_level,       3'd0);
    check("flush+req bus_req",  o_bus_request, 1'b1);
    check("flush+req bus_addr", o_bus_address, 32'h200C);
    fetch_wait("flush+req", d, lat);
    check("flush+req data", d, 32'hAAAA_210D);
    check("flush+req read", bus_log[bus_log.size() - 1], 32'h200C);

    // Plain flush stops prefetching
    wait_cycles(20);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush level", o_level, 3'd0);
    wait_cycles(5);
    check("flush no issue",   o_bus_request, 1'b0);
    check("flush level hold", o_level,       3'd0);

    // Address wrap
    fetch_start(32'hFFFF_FFFC, 1'b0);
    fetch_wait("wrap", d, lat);
    check("wrap data", d, 32'h5555_FEFD);
    @(posedge clk);
    #1;
    check("wrap bus_req",  o_bus_request, 1'b1);
    check("wrap bus_addr", o_bus_address, 32'h0);
    wait_cycles(6);
    bus_wait = 1000;
    wait_cycles(3);
    check("pre-reset bus_req", o_bus_request, 1'b1);
    check("pre-reset level",   o_level != 3'd0, 1'b1);

    // Asynchronous reset mid-read, between clock edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async bus_req",  o_bus_request, 1'b0);
    check("async bus_addr", o_bus_address, 32'h0);
    check("async level",    o_level,       3'd0);
    check("async ready",    o_ready,       1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_prefetch_queue.md
Name: cpu_prefetch_queue

Overview:
- Parametrised instruction prefetch queue between the CPU fetch stage and the instruction bus.
- Keeps up to DEPTH sequential words ahead of the CPU's current fetch address.
- Serves sequential fetches from the queue in one cycle. A non-sequential fetch or an explicit flush discards the queue and restarts fetching at the new address.
- Extends the single-word prefetcher with configurable depth, width and stride, an explicit flush input, a bypass path for in-flight words, and discard of stale bus responses.

Parameters:
- DEPTH, 4: queue entries; power of two, minimum 2.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: instruction word width.
- STRIDE, 4: address increment between sequential words.

Ports:
- i_clock  in  1  clock; all logic on rising edge.
- i_reset  in  1  reset; asynchronous, active-low (0 = reset).
- i_request  in  1  CPU fetch request; held until o_ready.
- o_ready  out  1  one-cycle pulse; o_rdata is valid in that cycle.
- i_address  in  ADDR_WIDTH  CPU fetch address; stable while i_request is high.
- o_rdata  out  DATA_WIDTH  fetched word.
- i_flush  in  1  discard queue contents (fence.i, redirect).
- o_level  out  log2(DEPTH)+1  number of valid queued words.
- o_bus_request  out  1  bus read request.
- i_bus_ready  in  1  bus read complete; i_bus_rdata valid.
- o_bus_address  out  ADDR_WIDTH  bus read address.
- i_bus_rdata  in  DATA_WIDTH  bus read data.

Behaviour:
Reset:
- i_reset low clears immediately, no clock needed: o_ready=0, o_rdata=0, o_bus_request=0, o_bus_address=0, o_level=0.
- Queue empty, no pending miss, discard flag clear.
- Reset during a bus transaction drops o_bus_request at once; the bus slave tolerates an abandoned read.

State held:
- Queue FIFO: DEPTH entries.
- head_addr: address of the head entry.
- fetch_addr: next address to fetch.
- inflight: one outstanding bus read at most.
- discard: the in-flight response is stale.
- pending_miss, miss_addr: a CPU miss waiting for its word.

Bus protocol:
- o_bus_request and o_bus_address are registered and held stable until i_bus_ready is sampled high.
- The request deasserts for at least one cycle after each completion.

Bus issue:
- A new read starts when the bus is idle and either pending_miss is set, or count+inflight < DEPTH and no miss is pending.
- Issue address is miss_addr for a pending miss, otherwise fetch_addr.

CPU side (i_request sampled at edge N, only while o_ready is low):
- Hit (count>0 and i_address==head_addr):
  - After edge N: o_rdata=head word, o_ready=1.
  - Pop the head; head_addr += STRIDE.
  - A bus completion on the same edge pushes into the queue; count is unchanged.
- Bypass (count==0, inflight, !discard, o_bus_address==i_address):
  - No flush; wait for the bus.
  - On completion, forward the word to the CPU, skip the queue, and set head_addr = fetch_addr.
- Miss (all other cases):
  - Flush queue; set pending_miss; miss_addr = i_address.
  - If a read is in flight, set discard.
- Miss completion:
  - o_rdata=i_bus_rdata, o_ready=1 after that edge.
  - head_addr = fetch_addr = miss_addr + STRIDE; count=0; pending_miss cleared.
  - Background prefetch resumes.
- Discarded completion: data dropped, discard cleared, no queue change.

o_ready timing:
- o_ready is high for exactly one cycle.
- i_request is ignored in the cycle o_ready is high.

Flush:
- i_flush at an edge empties the queue; sets discard if a read is in flight.
- No new prefetch issues until the next CPU request, which is a miss.
- i_flush and i_request on the same edge: flush is applied first, then the request is handled as a miss.

Arithmetic:
- All address increments are modulo 2^ADDR_WIDTH.
- With ADDR_WIDTH=32 and STRIDE=4, 0xFFFFFFFC+4 = 0x00000000.

Queue full:
- No bus issue at count+inflight == DEPTH.
- The queue never overflows; the full condition releases on the first pop.

o_level equals the queue count, registered.

Test Plan:
- Cold miss: reset, then request 0x100 with the bus returning 0xAAAA0001 after 3 cycles -> o_bus_address=0x100; o_ready pulses once with o_rdata=0xAAAA0001; next reads are at 0x104, 0x108, and so on.
- Sequential hits, DEPTH=4, zero-wait bus: after the 0x100 miss, queue fills to o_level=4 (0x104..0x110). Requests 0x104, 0x108, 0x10C each get o_ready 1 cycle after the request, with no bus wait. The bus refills, holding o_level between 3 and 4.
- Redirect with a read in flight: queue holds 0x104.., a read is in flight, request 0x2000 arrives. The in-flight data is discarded; the next bus read is 0x2000; o_rdata is the 0x2000 word; o_level=0 during the miss.
- Bypass: queue empty with a read to 0x108 in flight, request 0x108 -> no flush, no extra bus read; o_ready on the edge after i_bus_ready with that data.
- Flush and request together: i_flush and request 0x104 (a queue hit) on the same edge -> treated as a miss; bus reads 0x104 again.
- Wrap and async reset: miss at 0xFFFFFFFC -> the prefetch address after it is 0x00000000. Asserting i_reset low mid-read drops o_bus_request and o_level to 0 before the next clock edge.
